map_sprite_mover: RTL and testbench

- Multi-channel tile mover for the tile-map RAM: arbitrates move requests from N sprite controllers (pacman plus ghosts) and performs read-modify-write of whole map rows over the RAM's single shared address/write port.
- Generalises the single-sprite map writer with parametrised grid size, tile width and channel count, round-robin arbitration, wall blocking and bounds checking.
- Sits between the per-sprite location controllers and port B of the map RAM.

---
 rtl/map_pkg.sv | 41 ++++
 rtl/map_sprite_mover_rr_arbiter.sv | 54 +++++
 rtl/map_sprite_mover.sv | 205 ++++++++++++++++++++
 tb/tb_map_sprite_mover.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | map_pkg : FSM state codes, tile codes and row tile helpers        |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
package map_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RD_DST = 3'd1;
    localparam logic [2:0] ST_CHK    = 3'd2;
    localparam logic [2:0] ST_RD_SRC = 3'd3;
    localparam logic [2:0] ST_WR_SRC = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    localparam int TILE_BLANK  = 0;
    localparam int TILE_WALL   = 1;
    localparam int TILE_PELLET = 2;
    localparam int TILE_PACMAN = 4;
    localparam int TILE_GHOST  = 5;

    localparam int MAX_TILE_W = 8;
    localparam int MAX_WORD_W = 1024;

    // Column 0 sits at the MSB end of a ww-bit row word.
    function automatic logic [MAX_TILE_W-1:0] get_tile(input logic [MAX_WORD_W-1:0] word,
                                                       input int col, input int tw, input int ww);
        logic [MAX_WORD_W-1:0] t;
        t = (word >> (ww - (col + 1) * tw)) & ~({MAX_WORD_W{1'b1}} << tw);
        return t[MAX_TILE_W-1:0];
    endfunction

    function automatic logic [MAX_WORD_W-1:0] set_tile(input logic [MAX_WORD_W-1:0] word,
                                                       input int col, input int tw, input int ww,
                                                       input logic [MAX_TILE_W-1:0] code);
        logic [MAX_WORD_W-1:0] m;
        m = ~({MAX_WORD_W{1'b1}} << tw) << (ww - (col + 1) * tw);
        return (word & ~m) | ((MAX_WORD_W'(code) << (ww - (col + 1) * tw)) & m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/map_sprite_mover_rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter : round-robin grant, channel 0 first after reset       |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [NUM_CH-1:0] grant,
    output logic [IW-1:0]     grant_idx
);

    logic [IW-1:0] r_last;
    logic [IW-1:0] w_idx;
    logic          w_found;
    int            w_dist;
    int            w_best;

    // Smallest rotational distance past the last grant wins.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        w_dist  = 0;
        w_best  = NUM_CH;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i]) begin
                w_dist = (i + NUM_CH - int'(r_last) - 1) % NUM_CH;
                if (w_dist < w_best) begin
                    w_best  = w_dist;
                    w_idx   = IW'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign grant     = w_found ? (NUM_CH'(1) << w_idx) : '0;
    assign grant_idx = w_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= IW'(NUM_CH - 1);
        end else if (advance) begin
            r_last <= w_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/map_sprite_mover.sv
`default_nettype none
// +------------------------------------------------------------------+
// | map_sprite_mover : multi-channel row read-modify-write tile mover |
// | Option macro: UNDER_RESTORE_EN (restore tile under each sprite)   |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module map_sprite_mover
    import map_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int COLS       = 40,
    parameter int ROWS       = 30,
    parameter int TILE_W     = 4,
    parameter int RD_LAT     = 2,
    parameter int BLANK_CODE = TILE_BLANK,
    parameter int WALL_CODE  = TILE_WALL,
    localparam int XW     = $clog2(COLS),
    localparam int YW     = $clog2(ROWS),
    localparam int WORD_W = COLS * TILE_W
) (
    input  logic                     CLOCK_50,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH*XW-1:0]     cur_x,
    input  logic [NUM_CH*YW-1:0]     cur_y,
    input  logic [NUM_CH*XW-1:0]     nxt_x,
    input  logic [NUM_CH*YW-1:0]     nxt_y,
    input  logic [NUM_CH*TILE_W-1:0] sprite_code,
    output logic [NUM_CH-1:0]        ack,
    output logic [NUM_CH-1:0]        blocked,
    output logic                     busy,
    output logic [YW-1:0]            ram_addr,
    output logic                     ram_wren,
    output logic [WORD_W-1:0]        ram_wdata,
    input  logic [WORD_W-1:0]        ram_rdata
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [TILE_W-1:0] c_blank = TILE_W'(BLANK_CODE);
    localparam logic [TILE_W-1:0] c_wall  = TILE_W'(WALL_CODE);

    function automatic logic [TILE_W-1:0] tile_at(input logic [WORD_W-1:0] w, input int col);
        logic [MAX_TILE_W-1:0] t;
        t = get_tile(MAX_WORD_W'(w), col, TILE_W, WORD_W);
        return t[TILE_W-1:0];
    endfunction

    function automatic logic [WORD_W-1:0] tile_put(input logic [WORD_W-1:0] w, input int col,
                                                   input logic [TILE_W-1:0] code);
        logic [MAX_WORD_W-1:0] r;
        r = set_tile(MAX_WORD_W'(w), col, TILE_W, WORD_W, MAX_TILE_W'(code));
        return r[WORD_W-1:0];
    endfunction

    logic [2:0]        r_state;
    logic [IW-1:0]     r_ch;
    logic [XW-1:0]     r_cx, r_nx;
    logic [YW-1:0]     r_cy, r_ny;
    logic [TILE_W-1:0] r_code;
    logic [CW-1:0]     r_cnt;

    logic [XW-1:0]     w_cx_arr [NUM_CH];
    logic [XW-1:0]     w_nx_arr [NUM_CH];
    logic [YW-1:0]     w_cy_arr [NUM_CH];
    logic [YW-1:0]     w_ny_arr [NUM_CH];
    logic [TILE_W-1:0] w_code_arr [NUM_CH];

    logic [NUM_CH-1:0] w_gnt_oh;
    logic [IW-1:0]     w_gidx;
    logic              w_any, w_adv;
    logic [NUM_CH-1:0] w_ch_oh;
    logic [TILE_W-1:0] w_dst_tile, w_fill_now, w_fill_late;
    logic              w_block, w_noop, w_same;
    logic [WORD_W-1:0] w_dst_row, w_same_row, w_src_row;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
        assign w_cx_arr[g]   = cur_x[g*XW +: XW];
        assign w_nx_arr[g]   = nxt_x[g*XW +: XW];
        assign w_cy_arr[g]   = cur_y[g*YW +: YW];
        assign w_ny_arr[g]   = nxt_y[g*YW +: YW];
        assign w_code_arr[g] = sprite_code[g*TILE_W +: TILE_W];
    end

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (CLOCK_50),
        .rst_n     (reset_n),
        .req       (req),
        .advance   (w_adv),
        .grant     (w_gnt_oh),
        .grant_idx (w_gidx)
    );

    assign w_any   = |w_gnt_oh;
    assign w_adv   = (r_state == ST_IDLE) && w_any;
    assign busy    = (r_state != ST_IDLE);
    assign w_ch_oh = NUM_CH'(1) << r_ch;

    assign w_dst_tile = tile_at(ram_rdata, int'(r_nx));
    assign w_block    = (int'(r_nx) >= COLS) || (int'(r_ny) >= ROWS) || (w_dst_tile == c_wall);
    assign w_noop     = (r_nx == r_cx) && (r_ny == r_cy);
    assign w_same     = (r_ny == r_cy);
    assign w_dst_row  = tile_put(ram_rdata, int'(r_nx), r_code);
    assign w_same_row = tile_put(w_dst_row, int'(r_cx), w_fill_now);
    assign w_src_row  = tile_put(ram_rdata, int'(r_cx), w_fill_late);

`ifdef UNDER_RESTORE_EN
    logic [TILE_W-1:0] r_under [NUM_CH];
    logic [TILE_W-1:0] r_vac;

    // The fill for a cross-row source write must be the value from before this move's capture.
    assign w_fill_now  = r_under[r_ch];
    assign w_fill_late = r_vac;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) r_under[i] <= c_blank;
            r_vac <= c_blank;
        end else if (r_state == ST_CHK && !w_block && !w_noop) begin
            r_under[r_ch] <= w_dst_tile;
            r_vac         <= r_under[r_ch];
        end
    end
`else
    assign w_fill_now  = c_blank;
    assign w_fill_late = c_blank;
`endif

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_cx      <= '0;
            r_nx      <= '0;
            r_cy      <= '0;
            r_ny      <= '0;
            r_code    <= '0;
            r_cnt     <= '0;
            ack       <= '0;
            blocked   <= '0;
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            ram_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_ch     <= w_gidx;
                        r_cx     <= w_cx_arr[w_gidx];
                        r_cy     <= w_cy_arr[w_gidx];
                        r_nx     <= w_nx_arr[w_gidx];
                        r_ny     <= w_ny_arr[w_gidx];
                        r_code   <= w_code_arr[w_gidx];
                        ram_addr <= w_ny_arr[w_gidx];
                        r_cnt    <= CW'(RD_LAT - 1);
                        r_state  <= ST_RD_DST;
                    end
                end
                ST_RD_DST: begin
                    if (r_cnt == '0) r_state <= ST_CHK;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                ST_CHK: begin
                    if (w_block || w_noop) begin
                        ack     <= w_ch_oh;
                        blocked <= w_block ? w_ch_oh : '0;
                        r_state <= ST_DONE;
                    end else if (w_same) begin
                        ram_wren  <= 1'b1;
                        ram_wdata <= w_same_row;
                        ack       <= w_ch_oh;
                        r_state   <= ST_DONE;
                    end else begin
                        ram_wren  <= 1'b1;
                        ram_wdata <= w_dst_row;
                        r_cnt     <= CW'(RD_LAT);
                        r_state   <= ST_RD_SRC;
                    end
                end
                // First RD_SRC cycle still carries the destination write on nxt_y.
                ST_RD_SRC: begin
                    ram_wren <= 1'b0;
                    ram_addr <= r_cy;
                    if (r_cnt == '0) r_state <= ST_WR_SRC;
                    else             r_cnt   <= r_cnt - CW'(1);
                end
                ST_WR_SRC: begin
                    ram_wren  <= 1'b1;
                    ram_wdata <= w_src_row;
                    ack       <= w_ch_oh;
                    r_state   <= ST_DONE;
                end
                ST_DONE: begin
                    ram_wren <= 1'b0;
                    ack      <= '0;
                    blocked  <= '0;
                    r_state  <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_sprite_mover.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_map_sprite_mover : directed bench with a 2-cycle row RAM model |
// | Revision : 1.0                                                    |
// +------------------------------------------------------------------+
module tb_map_sprite_mover;

    localparam int NUM_CH = 4;
    localparam int COLS   = 40;
    localparam int ROWS   = 30;
    localparam int TILE_W = 4;
    localparam int XW     = 6;
    localparam int YW     = 5;
    localparam int WORD_W = 160;

    logic                     CLOCK_50 = 1'b0;
    logic                     reset_n  = 1'b0;
    logic [NUM_CH-1:0]        req = '0;
    logic [NUM_CH*XW-1:0]     cur_x = '0, nxt_x = '0;
    logic [NUM_CH*YW-1:0]     cur_y = '0, nxt_y = '0;
    logic [NUM_CH*TILE_W-1:0] sprite_code = '0;
    logic [NUM_CH-1:0]        ack, blocked;
    logic                     busy, ram_wren;
    logic [YW-1:0]            ram_addr;
    logic [WORD_W-1:0]        ram_wdata, ram_rdata;

    logic [WORD_W-1:0] mem [ROWS];
    logic [YW-1:0]     a1, a2;
    logic              tb_we = 1'b0;
    logic [YW-1:0]     tb_waddr = '0;
    logic [WORD_W-1:0] tb_wdata = '0;
    int                wr_cnt = 0;
    logic [YW-1:0]     wr_prev = '0, wr_last = '0;

    int checks = 0;
    int errors = 0;

    map_sprite_mover dut (
        .CLOCK_50    (CLOCK_50),
        .reset_n     (reset_n),
        .req         (req),
        .cur_x       (cur_x),
        .cur_y       (cur_y),
        .nxt_x       (nxt_x),
        .nxt_y       (nxt_y),
        .sprite_code (sprite_code),
        .ack         (ack),
        .blocked     (blocked),
        .busy        (busy),
        .ram_addr    (ram_addr),
        .ram_wren    (ram_wren),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    assign ram_rdata = (int'(a2) < ROWS) ? mem[a2] : '0;

    always @(posedge CLOCK_50) begin
        a1 <= ram_addr;
        a2 <= a1;
        if (ram_wren === 1'b1) begin
            if (int'(ram_addr) < ROWS) mem[ram_addr] <= ram_wdata;
            wr_cnt  = wr_cnt + 1;
            wr_prev = wr_last;
            wr_last = ram_addr;
        end else if (tb_we) begin
            mem[tb_waddr] <= tb_wdata;
        end
    end

    task automatic check(input string tag, input logic [WORD_W-1:0] obs, input logic [WORD_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_row(input int r, input logic [WORD_W-1:0] d);
        tb_waddr = YW'(r);
        tb_wdata = d;
        tb_we    = 1'b1;
        @(posedge CLOCK_50);
        #1 tb_we = 1'b0;
    endtask

    task automatic set_ch(input int ch, input int cx, input int cy, input int nx, input int ny, input int code);
        cur_x[ch*XW +: XW]             = XW'(cx);
        cur_y[ch*YW +: YW]             = YW'(cy);
        nxt_x[ch*XW +: XW]             = XW'(nx);
        nxt_y[ch*YW +: YW]             = YW'(ny);
        sprite_code[ch*TILE_W +: TILE_W] = TILE_W'(code);
    endtask

    task automatic wait_ack(input int ch, output int lat, output logic blk);
        lat = -1;
        blk = 1'bx;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (ack[ch]) begin
                lat = n;
                blk = blocked[ch];
                break;
            end
        end
    endtask

    task automatic next_ack(output int ch);
        ch = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLOCK_50);
            #1;
            if (|ack) begin
                for (int i = 0; i < NUM_CH; i++) if (ack[i]) ch = i;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        logic        blk;
        int          base;
        int          ch;
        int          order [6];
        order = '{0, 1, 3, 0, 1, 3};

        repeat (3) @(posedge CLOCK_50);
        #1;
        check("rst_ack", WORD_W'(ack), 0);
        check("rst_blocked", WORD_W'(blocked), 0);
        check("rst_busy", WORD_W'(busy), 0);
        check("rst_wren", WORD_W'(ram_wren), 0);
        check("rst_addr", WORD_W'(ram_addr), 0);
        reset_n = 1'b1;

        // Same-row move (5,3)->(6,3)
        load_row(3, {40{4'h2}});
        set_ch(0, 5, 3, 6, 3, 4);
        base = wr_cnt;
        req[0] = 1'b1;
        wait_ack(0, lat, blk);
        req[0] = 1'b0;
        check("same_lat", WORD_W'(lat), 4);
        check("same_blocked", WORD_W'(blk), 0);
        @(posedge CLOCK_50);
        #1;
        check("same_wr_cnt", WORD_W'(wr_cnt - base), 1);
        check("same_wr_addr", WORD_W'(wr_last), 3);
        check("same_row3", mem[3], {20'h22222, 8'h04, {33{4'h2}}});

        // Cross-row move (10,7)->(10,8)
        load_row(7, {40'h2222222222, 4'h4, {29{4'h2}}});
        load_row(8, {40{4'h2}});
        set_ch(0, 10, 7, 10, 8, 4);
        base = wr_cnt;
        req[0] = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("cross_busy", WORD_W'(busy), 1);
        wait_ack(0, lat, blk);
        req[0] = 1'b0;
        check("cross_lat", WORD_W'(lat + 1), 8);
        @(posedge CLOCK_50);
        #1;
        check("cross_wr_cnt", WORD_W'(wr_cnt - base), 2);
        check("cross_wr_first", WORD_W'(wr_prev), 8);
        check("cross_wr_second", WORD_W'(wr_last), 7);
        check("cross_row8", mem[8], {40'h2222222222, 4'h4, {29{4'h2}}});
        check("cross_row7", mem[7], {40'h2222222222, 4'h0, {29{4'h2}}});

        // Wall at destination, then column and row out of range
        load_row(3, {20'h22222, 8'h21, {33{4'h2}}});
        base = wr_cnt;
        set_ch(0, 5, 3, 6, 3, 4);
        req[0] = 1'b1;
        wait_ack(0, lat, blk);
        req[0] = 1'b0;
        check("wall_lat", WORD_W'(lat), 4);
        check("wall_blocked", WORD_W'(blk), 1);
        @(posedge CLOCK_50);
        #1;
        set_ch(0, 5, 3, 40, 3, 4);
        req[0] = 1'b1;
        wait_ack(0, lat, blk);
        req[0] = 1'b0;
        check("oobx_lat", WORD_W'(lat), 4);
        check("oobx_blocked", WORD_W'(blk), 1);
        @(posedge CLOCK_50);
        #1;
        set_ch(0, 5, 3, 5, 30, 4);
        req[0] = 1'b1;
        wait_ack(0, lat, blk);
        req[0] = 1'b0;
        check("ooby_blocked", WORD_W'(blk), 1);
        @(posedge CLOCK_50);
        #1;
        // No-op move: same cell
        set_ch(0, 5, 3, 5, 3, 4);
        req[0] = 1'b1;
        wait_ack(0, lat, blk);
        req[0] = 1'b0;
        check("noop_lat", WORD_W'(lat), 4);
        check("noop_blocked", WORD_W'(blk), 0);
        @(posedge CLOCK_50);
        #1;
        check("refused_no_write", WORD_W'(wr_cnt - base), 0);
        check("wall_row3", mem[3], {20'h22222, 8'h21, {33{4'h2}}});

        // Round-robin from reset
        reset_n = 1'b0;
        @(posedge CLOCK_50);
        #1 reset_n = 1'b1;
        set_ch(0, 3, 3, 3, 3, 4);
        set_ch(1, 1, 1, 1, 1, 4);
        set_ch(3, 2, 2, 2, 2, 4);
        req = 4'b1010;
        next_ack(ch);
        check("rr_first", WORD_W'(ch), 1);
        next_ack(ch);
        check("rr_second", WORD_W'(ch), 3);
        req[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            next_ack(ch);
            check($sformatf("rr_order%0d", k), WORD_W'(ch), WORD_W'(order[k]));
        end
        req = '0;
        @(posedge CLOCK_50);
        #1;

        // Reset during the destination write cycle of a cross-row move
        load_row(7, {40'h2222222222, 4'h4, {29{4'h2}}});
        load_row(8, {40{4'h2}});
        set_ch(2, 10, 7, 10, 8, 4);
        req = 4'b0100;
        repeat (4) @(posedge CLOCK_50);
        #1;
        check("pre_rst_wren", WORD_W'(ram_wren), 1);
        check("pre_rst_addr", WORD_W'(ram_addr), 8);
        #3 reset_n = 1'b0;
        #1;
        check("mid_rst_wren", WORD_W'(ram_wren), 0);
        check("mid_rst_busy", WORD_W'(busy), 0);
        @(posedge CLOCK_50);
        #1 reset_n = 1'b1;
        wait_ack(2, lat, blk);
        req = '0;
        check("regrant_lat", WORD_W'(lat), 8);
        @(posedge CLOCK_50);
        #1;
        check("regrant_row8", mem[8], {40'h2222222222, 4'h4, {29{4'h2}}});
        check("regrant_row7", mem[7], {40'h2222222222, 4'h0, {29{4'h2}}});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
